// File: rtl/matmult_stream.sv
// NxN matrix multiplier over valid/ready streams: load A then B, run N^3 MAC cycles, drain C row-major.
// Optional build macro MATMULT_SIGNED_EN switches operands and results to two's complement.
module matmult_stream #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 2*DW+$clog2(N)+1
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          calc_done
);

    localparam int NN = N*N;
    localparam int IW = $clog2(N);
    localparam int MW = $clog2(NN);
    localparam logic [IW-1:0] K_LAST   = IW'(N-1);
    localparam logic [MW-1:0] E_LAST   = MW'(NN-1);
    localparam logic [MW-1:0] ROW_STEP = MW'(N);
    localparam logic [MW-1:0] ROW_BACK = MW'(N-1);

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    state_t        state_reg;
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [AW-1:0] c_mem [NN];

    logic          ld_b_reg;
    logic [MW-1:0] ld_addr_reg;
    logic [IW-1:0] k_reg, j_reg;
    logic [MW-1:0] a_addr_reg, b_addr_reg, c_addr_reg, rd_addr_reg;
    logic [AW-1:0] acc_reg;
    logic          in_ready_reg, out_valid_reg, busy_reg, calc_done_reg;
    logic [AW-1:0] out_data_reg;

    logic [DW-1:0] a_op, b_op;
    logic          a_fill, b_fill;
    logic [AW-1:0] a_ext, b_ext, prod, sum;
    logic          load_fire, c_wr;

    assign a_op = a_mem[a_addr_reg];
    assign b_op = b_mem[b_addr_reg];
`ifdef MATMULT_SIGNED_EN
    assign a_fill = a_op[DW-1];
    assign b_fill = b_op[DW-1];
`else
    assign a_fill = 1'b0;
    assign b_fill = 1'b0;
`endif
    // Product taken modulo 2^AW; the sign fill makes this correct for both builds.
    assign a_ext = {{(AW-DW){a_fill}}, a_op};
    assign b_ext = {{(AW-DW){b_fill}}, b_op};
    assign prod  = a_ext * b_ext;
    assign sum   = (k_reg == '0) ? prod : acc_reg + prod;

    assign load_fire = (state_reg == LOAD) && in_valid && !clear;
    assign c_wr      = (state_reg == CALC) && (k_reg == K_LAST) && !clear;

    always_ff @(posedge sys_clk) begin
        if (load_fire) begin
            if (ld_b_reg)
                b_mem[ld_addr_reg] <= in_data;
            else
                a_mem[ld_addr_reg] <= in_data;
        end
        if (c_wr)
            c_mem[c_addr_reg] <= sum;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LOAD;
            ld_b_reg      <= 1'b0;
            ld_addr_reg   <= '0;
            k_reg         <= '0;
            j_reg         <= '0;
            a_addr_reg    <= '0;
            b_addr_reg    <= '0;
            c_addr_reg    <= '0;
            rd_addr_reg   <= '0;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            calc_done_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (clear) begin
            state_reg     <= LOAD;
            ld_b_reg      <= 1'b0;
            ld_addr_reg   <= '0;
            k_reg         <= '0;
            j_reg         <= '0;
            a_addr_reg    <= '0;
            b_addr_reg    <= '0;
            c_addr_reg    <= '0;
            rd_addr_reg   <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            calc_done_reg <= 1'b0;
        end else begin
            calc_done_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        if (ld_addr_reg == E_LAST) begin
                            ld_addr_reg <= '0;
                            ld_b_reg    <= ~ld_b_reg;
                            if (ld_b_reg) begin
                                state_reg    <= CALC;
                                in_ready_reg <= 1'b0;
                                busy_reg     <= 1'b1;
                            end
                        end else begin
                            ld_addr_reg <= ld_addr_reg + MW'(1);
                        end
                    end
                end
                CALC: begin
                    acc_reg <= sum;
                    if (k_reg != K_LAST) begin
                        k_reg      <= k_reg + IW'(1);
                        a_addr_reg <= a_addr_reg + MW'(1);
                        b_addr_reg <= b_addr_reg + ROW_STEP;
                    end else begin
                        k_reg <= '0;
                        if (c_addr_reg == E_LAST) begin
                            state_reg     <= DRAIN;
                            j_reg         <= '0;
                            a_addr_reg    <= '0;
                            b_addr_reg    <= '0;
                            c_addr_reg    <= '0;
                            out_valid_reg <= 1'b1;
                            calc_done_reg <= 1'b1;
                            out_data_reg  <= c_mem[0];
                        end else begin
                            c_addr_reg <= c_addr_reg + MW'(1);
                            // Next column rewinds A to the row start; next row just continues.
                            if (j_reg != K_LAST) begin
                                j_reg      <= j_reg + IW'(1);
                                a_addr_reg <= a_addr_reg - ROW_BACK;
                                b_addr_reg <= MW'(j_reg) + MW'(1);
                            end else begin
                                j_reg      <= '0;
                                a_addr_reg <= a_addr_reg + MW'(1);
                                b_addr_reg <= '0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_addr_reg == E_LAST) begin
                            state_reg     <= LOAD;
                            rd_addr_reg   <= '0;
                            out_valid_reg <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                        end else begin
                            rd_addr_reg  <= rd_addr_reg + MW'(1);
                            out_data_reg <= c_mem[rd_addr_reg + MW'(1)];
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;
    assign calc_done = calc_done_reg;

endmodule

// File: tb/tb_matmult_stream.sv
// Bench for matmult_stream: table vectors, random products vs a matrix model, and hand sequences
// for back-pressure, clear, asynchronous reset and an N=3 instance.
module tb_matmult_stream;

    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int AW  = 2*DW+$clog2(N)+1;
    localparam int AW3 = 2*DW+$clog2(3)+1;

    logic          sys_clk = 1'b0;
    logic          rst, clear, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, busy, calc_done;
    logic [AW-1:0] out_data;

    logic           d3_clear, d3_in_valid, d3_out_ready;
    logic [DW-1:0]  d3_in_data;
    logic           d3_in_ready, d3_out_valid, d3_busy, d3_calc_done;
    logic [AW3-1:0] d3_out_data;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    matmult_stream #(.N(N), .DW(DW)) dut (
        .sys_clk(sys_clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .calc_done(calc_done)
    );

    matmult_stream #(.N(3), .DW(DW)) dut3 (
        .sys_clk(sys_clk), .rst(rst), .clear(d3_clear),
        .in_valid(d3_in_valid), .in_data(d3_in_data), .in_ready(d3_in_ready),
        .out_valid(d3_out_valid), .out_data(d3_out_data), .out_ready(d3_out_ready),
        .busy(d3_busy), .calc_done(d3_calc_done)
    );

    typedef struct packed {
        logic [8*DW-1:0] ops;
        logic [4*AW-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [8*DW-1:0] pack8(input int e0, input int e1, input int e2, input int e3,
                                              input int e4, input int e5, input int e6, input int e7);
        return {DW'(e0), DW'(e1), DW'(e2), DW'(e3), DW'(e4), DW'(e5), DW'(e6), DW'(e7)};
    endfunction

    function automatic logic [4*AW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {AW'(c0), AW'(c1), AW'(c2), AW'(c3)};
    endfunction

    function automatic longint opval(input logic [DW-1:0] x);
`ifdef MATMULT_SIGNED_EN
        return longint'($signed(x));
`else
        return longint'(x);
`endif
    endfunction

    // C = A x B computed directly from the matrix definition.
    function automatic void ref_model(input logic [DW-1:0] ops [8], output logic [AW-1:0] c [4]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int k = 0; k < N; k++)
                    s += opval(ops[i*N+k]) * opval(ops[N*N+k*N+j]);
                c[i*N+j] = AW'(s);
            end
    endfunction

    task automatic send_ops(input logic [DW-1:0] ops [8], input bit gaps);
        for (int e = 0; e < 8; e++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(negedge sys_clk);
                end
            in_valid = 1'b1;
            in_data  = ops[e];
            @(negedge sys_clk);
        end
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the last operand was accepted; junk on in_valid must be ignored.
    task automatic wait_first(input string tag);
        int cnt = 1;
        while (!out_valid && cnt < 64) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = DW'($urandom);
            @(negedge sys_clk);
            cnt++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, cnt, N*N*N+1);
        check({tag, " calc_done"}, calc_done, 1);
        check({tag, " busy"}, busy, 1);
    endtask

    task automatic drain(input logic [AW-1:0] exp [4], input bit bp, input string tag);
        int idx = 0;
        int guard = 0;
        while (idx < 4 && guard < 200) begin
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                $display("%s out[%0d] = %0d", tag, idx, out_data);
                check({tag, " out_data"}, out_data, exp[idx]);
                idx++;
            end
            @(negedge sys_clk);
            guard++;
            if (guard == 1) check({tag, " calc_done pulse"}, calc_done, 0);
        end
        out_ready = 1'b0;
        check({tag, " results received"}, idx, 4);
        if (!bp) check({tag, " drain length"}, guard, 4);
        check({tag, " out_valid end"}, out_valid, 0);
        check({tag, " in_ready end"}, in_ready, 1);
        check({tag, " busy end"}, busy, 0);
    endtask

    task automatic unpack_vec(input vec_t v, output logic [DW-1:0] ops [8], output logic [AW-1:0] exp [4]);
        for (int e = 0; e < 8; e++) ops[e] = v.ops[(7-e)*DW +: DW];
        for (int e = 0; e < 4; e++) exp[e] = v.exp[(3-e)*AW +: AW];
    endtask

    task automatic run_arrays(input logic [DW-1:0] ops [8], input logic [AW-1:0] exp [4],
                              input bit bp, input bit gaps, input string tag);
        send_ops(ops, gaps);
        wait_first(tag);
        drain(exp, bp, tag);
    endtask

    initial begin
        logic [DW-1:0] ops [8];
        logic [AW-1:0] exp [4];
        logic [DW-1:0] bops [8];
        logic [AW-1:0] bexp [4];
        int cnt;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        d3_clear = 1'b0; d3_in_valid = 1'b0; d3_in_data = '0; d3_out_ready = 1'b0;

        vecs[0] = '{ops: pack8(1, 2, 3, 4, 5, 6, 7, 8), exp: pack4(19, 22, 43, 50)};
`ifdef MATMULT_SIGNED_EN
        vecs[1] = '{ops: pack8(-1, 2, 3, -4, 5, 6, 7, 8), exp: pack4(9, 10, -13, -14)};
        vecs[2] = '{ops: pack8(255, 255, 255, 255, 255, 255, 255, 255), exp: pack4(2, 2, 2, 2)};
`else
        vecs[1] = '{ops: pack8(255, 255, 255, 255, 255, 255, 255, 255),
                    exp: pack4(130050, 130050, 130050, 130050)};
        vecs[2] = '{ops: pack8(1, 0, 0, 1, 9, 8, 7, 6), exp: pack4(9, 8, 7, 6)};
`endif
        vecs[3] = '{ops: pack8(2, 0, 0, 2, 3, 4, 5, 6), exp: pack4(6, 8, 10, 12)};
        unpack_vec(vecs[0], bops, bexp);

        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset busy", busy, 0);
        check("reset calc_done", calc_done, 0);

        for (int v = 0; v < 4; v++) begin
            unpack_vec(vecs[v], ops, exp);
            run_arrays(ops, exp, 1'b0, 1'b0, $sformatf("vec%0d", v));
        end

        // Hold off the consumer: first result must stay put.
        send_ops(bops, 1'b0);
        wait_first("bp");
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, 19);
            @(negedge sys_clk);
        end
        drain(bexp, 1'b0, "bp");

        // Clear after three operands, colliding with a fourth transfer that must be dropped.
        for (int e = 0; e < 3; e++) begin
            in_valid = 1'b1; in_data = bops[e];
            @(negedge sys_clk);
        end
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
        @(negedge sys_clk);
        clear = 1'b0; in_valid = 1'b0;
        check("abort in_ready", in_ready, 1);
        run_arrays(bops, bexp, 1'b0, 1'b0, "abort");

        // Clear together with the final result transfer.
        send_ops(bops, 1'b0);
        wait_first("clrlast");
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            check("clrlast out_data", out_data, bexp[r]);
            @(negedge sys_clk);
        end
        clear = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0; out_ready = 1'b0;
        check("clrlast out_valid", out_valid, 0);
        check("clrlast in_ready", in_ready, 1);
        check("clrlast busy", busy, 0);
        run_arrays(bops, bexp, 1'b0, 1'b0, "after_clr");

        // Asynchronous reset in the middle of CALC.
        send_ops(bops, 1'b0);
        repeat (3) @(negedge sys_clk);
        check("midcalc busy", busy, 1);
        check("midcalc in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst in_ready", in_ready, 1);
        check("async rst busy", busy, 0);
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        run_arrays(bops, bexp, 1'b0, 1'b0, "after_rst");

        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < 8; e++) ops[e] = DW'($urandom);
            ref_model(ops, exp);
            run_arrays(ops, exp, 1'b1, 1'b1, $sformatf("rand%0d", r));
        end

        // N=3 instance: identity x (1..9).
        for (int e = 0; e < 18; e++) begin
            d3_in_valid = 1'b1;
            d3_in_data  = (e < 9) ? ((e % 4 == 0) ? DW'(1) : DW'(0)) : DW'(e - 8);
            @(negedge sys_clk);
        end
        d3_in_valid = 1'b0;
        cnt = 1;
        while (!d3_out_valid && cnt < 100) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("n3 latency", cnt, 28);
        check("n3 calc_done", d3_calc_done, 1);
        d3_out_ready = 1'b1;
        for (int r = 0; r < 9; r++) begin
            $display("n3 out[%0d] = %0d", r, d3_out_data);
            check("n3 out_valid", d3_out_valid, 1);
            check("n3 out_data", d3_out_data, r + 1);
            @(negedge sys_clk);
        end
        d3_out_ready = 1'b0;
        check("n3 out_valid end", d3_out_valid, 0);
        check("n3 in_ready end", d3_in_ready, 1);
        check("n3 busy end", d3_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
